timing_gen_vg: RTL and testbench

Raster timing generator for the video generator. It sits directly downstream of the format decoder and consumes its per-format timing words: INTERLACED, V_*_0/1, H_*, HV_OFFSET_0/1. It runs horizontal, vertical and field counters and produces registered HSYNC, VSYNC, DE, FIELD, pixel coordinates and a start-of-frame strobe for the pattern generator and the transmitter interface.

---
 rtl/vg_pkg.sv | 68 ++++++
 rtl/vg_region_cmp.sv | 29 ++
 rtl/timing_gen_vg.sv | 194 +++++++++++++++++++
 tb/tb_timing_gen_vg.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vg_pkg.sv
// Shared definitions for the video generator: counter width, FSM encoding, timing record.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package vg_pkg;

    localparam int CW = 12;
    localparam logic [CW-1:0] CW_ONE = CW'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Timing words as delivered by the format decoder; index [f] selects field f.
    typedef struct packed {
        logic               interlaced;
        logic [1:0][CW-1:0] v_total;
        logic [1:0][CW-1:0] v_fp;
        logic [1:0][CW-1:0] v_bp;
        logic [1:0][CW-1:0] v_sync;
        logic [CW-1:0]      h_total;
        logic [CW-1:0]      h_fp;
        logic [CW-1:0]      h_bp;
        logic [CW-1:0]      h_sync;
        logic [1:0][CW-1:0] hv_offset;
    } timing_t;

    // Shadowed decode view of a timing record: region bounds are precomputed at
    // latch time so the per-pixel path only compares counters against registers.
    typedef struct packed {
        logic               interlaced;
        logic [CW-1:0]      h_last;
        logic [CW-1:0]      h_sync_end;
        logic [CW-1:0]      h_act_start;
        logic [CW-1:0]      h_act_end;
        logic [1:0][CW-1:0] v_last;
        logic [1:0][CW-1:0] v_act_start;
        logic [1:0][CW-1:0] v_act_end;
        logic [1:0][CW-1:0] v_sync;
        logic [1:0][CW-1:0] hv_offset;
    } bounds_t;

    // A format is runnable only with non-zero line length and field-0 height.
    function automatic logic timing_valid(input timing_t t);
        return (t.h_total != '0) && (t.v_total[0] != '0);
    endfunction

    // Unsigned CW-bit bound arithmetic; porch/sync sums are assumed below totals.
    function automatic bounds_t calc_bounds(input timing_t t);
        bounds_t b;
        b                = '0;
        b.interlaced     = t.interlaced;
        b.h_last         = t.h_total - CW_ONE;
        b.h_sync_end     = t.h_sync;
        b.h_act_start    = t.h_sync + t.h_bp;
        b.h_act_end      = t.h_total - t.h_fp;
        b.v_last[0]      = t.v_total[0] - CW_ONE;
        b.v_last[1]      = t.v_total[1] - CW_ONE;
        b.v_act_start[0] = t.v_sync[0] + t.v_bp[0];
        b.v_act_start[1] = t.v_sync[1] + t.v_bp[1];
        b.v_act_end[0]   = t.v_total[0] - t.v_fp[0];
        b.v_act_end[1]   = t.v_total[1] - t.v_fp[1];
        b.v_sync         = t.v_sync;
        b.hv_offset      = t.hv_offset;
        return b;
    endfunction

endpackage

// File: rtl/vg_region_cmp.sv
// Registered in-region flag: high when start <= cnt < end and enabled.
// Latency: 1 cycle from counter to flag.
// Backpressure: none; evaluates every clock.
module vg_region_cmp
    import vg_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic [CW-1:0] i_cnt,
    input  logic [CW-1:0] i_start,
    input  logic [CW-1:0] i_end,
    output logic          o_in
);

    logic r_in;

    // Half-open interval test, forced low while the generator is idle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_in <= 1'b0;
        end else begin
            r_in <= i_en && (i_cnt >= i_start) && (i_cnt < i_end);
        end
    end

    assign o_in = r_in;

endmodule

// File: rtl/timing_gen_vg.sv
// Raster timing generator: h/v/field counters decoded into sync, DE, coordinates and SOF.
// Latency: every output is registered one cycle after the counter state it decodes.
// Backpressure: none; free-running at one pixel per clock once started.
module timing_gen_vg
    import vg_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_interlaced,
    input  logic [CW-1:0] i_v_total_0,
    input  logic [CW-1:0] i_v_fp_0,
    input  logic [CW-1:0] i_v_bp_0,
    input  logic [CW-1:0] i_v_sync_0,
    input  logic [CW-1:0] i_v_total_1,
    input  logic [CW-1:0] i_v_fp_1,
    input  logic [CW-1:0] i_v_bp_1,
    input  logic [CW-1:0] i_v_sync_1,
    input  logic [CW-1:0] i_h_total,
    input  logic [CW-1:0] i_h_fp,
    input  logic [CW-1:0] i_h_bp,
    input  logic [CW-1:0] i_h_sync,
    input  logic [CW-1:0] i_hv_offset_0,
    input  logic [CW-1:0] i_hv_offset_1,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic          o_field,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_sof
);

    timing_t       w_in;
    logic          w_in_valid;
    state_t        r_state;
    logic          r_start;
    bounds_t       r_dec;
    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic          r_fld;
    logic          w_run;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_hact;
    logic          w_vact;
    logic          w_de;
    logic          r_vsync;
    logic          r_field;
    logic          r_sof;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;

    assign w_in.interlaced   = i_interlaced;
    assign w_in.v_total[0]   = i_v_total_0;
    assign w_in.v_total[1]   = i_v_total_1;
    assign w_in.v_fp[0]      = i_v_fp_0;
    assign w_in.v_fp[1]      = i_v_fp_1;
    assign w_in.v_bp[0]      = i_v_bp_0;
    assign w_in.v_bp[1]      = i_v_bp_1;
    assign w_in.v_sync[0]    = i_v_sync_0;
    assign w_in.v_sync[1]    = i_v_sync_1;
    assign w_in.h_total      = i_h_total;
    assign w_in.h_fp         = i_h_fp;
    assign w_in.h_bp         = i_h_bp;
    assign w_in.h_sync       = i_h_sync;
    assign w_in.hv_offset[0] = i_hv_offset_0;
    assign w_in.hv_offset[1] = i_hv_offset_1;

    assign w_in_valid = timing_valid(w_in);
    assign w_run      = (r_state == ST_RUN);
    assign w_h_last   = (r_h == r_dec.h_last);
    assign w_v_last   = (r_v == r_dec.v_last[r_fld]);

    // Control FSM and raster counters. In IDLE an accepted EN arms r_start, and the
    // shadow is loaded one clock later, so the first decoded cycle lands two clocks
    // after EN is sampled. At frame end the shadow is reloaded without a gap.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_start <= 1'b0;
            r_dec   <= '0;
            r_h     <= '0;
            r_v     <= '0;
            r_fld   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_h   <= '0;
                    r_v   <= '0;
                    r_fld <= 1'b0;
                    if (r_start && w_in_valid) begin
                        r_dec   <= calc_bounds(w_in);
                        r_state <= ST_RUN;
                        r_start <= 1'b0;
                    end else begin
                        r_start <= i_en && w_in_valid;
                    end
                end
                ST_RUN: begin
                    if (w_h_last) begin
                        r_h <= '0;
                        if (w_v_last) begin
                            r_v <= '0;
                            if (r_dec.interlaced && !r_fld) begin
                                r_fld <= 1'b1;
                            end else begin
                                r_fld <= 1'b0;
                                if (i_en && w_in_valid) begin
                                    r_dec <= calc_bounds(w_in);
                                end else begin
                                    r_state <= ST_IDLE;
                                end
                            end
                        end else begin
                            r_v <= r_v + CW_ONE;
                        end
                    end else begin
                        r_h <= r_h + CW_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    vg_region_cmp u_hsync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_run),
        .i_cnt   (r_h),
        .i_start ('0),
        .i_end   (r_dec.h_sync_end),
        .o_in    (o_hsync)
    );

    vg_region_cmp u_hact (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_run),
        .i_cnt   (r_h),
        .i_start (r_dec.h_act_start),
        .i_end   (r_dec.h_act_end),
        .o_in    (w_hact)
    );

    vg_region_cmp u_vact (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_run),
        .i_cnt   (r_v),
        .i_start (r_dec.v_act_start[r_fld]),
        .i_end   (r_dec.v_act_end[r_fld]),
        .o_in    (w_vact)
    );

    // Registered VSYNC edges at the per-field offset, plus field, SOF and raw coordinates.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vsync <= 1'b0;
            r_field <= 1'b0;
            r_sof   <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
        end else if (w_run) begin
            r_field <= r_fld;
            r_sof   <= !r_fld && (r_h == '0) && (r_v == '0);
            r_x     <= r_h - r_dec.h_act_start;
            r_y     <= r_v - r_dec.v_act_start[r_fld];
            if (r_h == r_dec.hv_offset[r_fld]) begin
                if (r_v == r_dec.v_sync[r_fld]) begin
                    r_vsync <= 1'b0;
                end else if (r_v == '0) begin
                    r_vsync <= 1'b1;
                end
            end
        end else begin
            r_vsync <= 1'b0;
            r_field <= 1'b0;
            r_sof   <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
        end
    end

    assign w_de    = w_hact && w_vact;
    assign o_de    = w_de;
    assign o_vsync = r_vsync;
    assign o_field = r_field;
    assign o_sof   = r_sof;
    assign o_x     = w_de ? r_x : '0;
    assign o_y     = w_de ? r_y : '0;

endmodule

// File: tb/tb_timing_gen_vg.sv
// Scoreboard bench for timing_gen_vg using small hand-sized raster formats.
// Stimulus pushes per-frame expected summaries; a monitor measures each SOF-to-SOF window.
// Free-running DUT: no backpressure is exercised.
module tb_timing_gen_vg;
    import vg_pkg::*;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_en;
    logic          i_interlaced;
    logic [CW-1:0] i_v_total_0, i_v_fp_0, i_v_bp_0, i_v_sync_0;
    logic [CW-1:0] i_v_total_1, i_v_fp_1, i_v_bp_1, i_v_sync_1;
    logic [CW-1:0] i_h_total, i_h_fp, i_h_bp, i_h_sync;
    logic [CW-1:0] i_hv_offset_0, i_hv_offset_1;
    logic          o_hsync, o_vsync, o_de, o_field, o_sof;
    logic [CW-1:0] o_x, o_y;

    typedef struct {
        string tag;
        int    period;  // negative: not checked
        int    hs;
        int    vs;
        int    de;
        int    xs;
        int    ys;
        int    f1;
        int    bad;
        int    vsr;
    } rec_t;

    rec_t exp_q[$];
    int   n_checks    = 0;
    int   n_pass      = 0;
    int   cyc         = 0;
    int   discard_req = 0;

    timing_gen_vg dut (
        .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_interlaced(i_interlaced),
        .i_v_total_0(i_v_total_0), .i_v_fp_0(i_v_fp_0), .i_v_bp_0(i_v_bp_0), .i_v_sync_0(i_v_sync_0),
        .i_v_total_1(i_v_total_1), .i_v_fp_1(i_v_fp_1), .i_v_bp_1(i_v_bp_1), .i_v_sync_1(i_v_sync_1),
        .i_h_total(i_h_total), .i_h_fp(i_h_fp), .i_h_bp(i_h_bp), .i_h_sync(i_h_sync),
        .i_hv_offset_0(i_hv_offset_0), .i_hv_offset_1(i_hv_offset_1),
        .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de), .o_field(o_field),
        .o_x(o_x), .o_y(o_y), .o_sof(o_sof)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic rec_t mk(input string tag, input int p, input int hs, input int vs,
                                input int de, input int xs, input int ys, input int f1, input int vsr);
        rec_t r;
        r.tag = tag; r.period = p; r.hs = hs; r.vs = vs; r.de = de;
        r.xs = xs; r.ys = ys; r.f1 = f1; r.bad = 0; r.vsr = vsr;
        return r;
    endfunction

    function automatic int outs_word();
        return int'({o_hsync, o_vsync, o_de, o_field, o_sof, o_x, o_y});
    endfunction

    task automatic set_fmt(input int ht, input int hf, input int hb, input int hsy, input bit il,
                           input int vt0, input int vf0, input int vb0, input int vs0,
                           input int vt1, input int vf1, input int vb1, input int vs1,
                           input int off0, input int off1);
        i_h_total = CW'(ht); i_h_fp = CW'(hf); i_h_bp = CW'(hb); i_h_sync = CW'(hsy);
        i_interlaced = il;
        i_v_total_0 = CW'(vt0); i_v_fp_0 = CW'(vf0); i_v_bp_0 = CW'(vb0); i_v_sync_0 = CW'(vs0);
        i_v_total_1 = CW'(vt1); i_v_fp_1 = CW'(vf1); i_v_bp_1 = CW'(vb1); i_v_sync_1 = CW'(vs1);
        i_hv_offset_0 = CW'(off0); i_hv_offset_1 = CW'(off1);
    endtask

    // Format A: 10-pixel lines (sync 2, bp 2, 5 active, fp 1), 8 lines (sync 1, bp 1, 5 active, fp 1).
    task automatic fmt_a(); set_fmt(10, 1, 2, 2, 1'b0, 8, 1, 1, 1, 0, 0, 0, 0, 0, 0); endtask
    // Format C: 12-pixel lines (sync 3, bp 2, 5 active, fp 2), same vertical as A.
    task automatic fmt_c(); set_fmt(12, 2, 2, 3, 1'b0, 8, 1, 1, 1, 0, 0, 0, 0, 0, 0); endtask
    // Format B: interlaced, A's lines, field 0 of 6 lines, field 1 of 7 lines, field-1 VSYNC at h=5.
    task automatic fmt_b(); set_fmt(10, 1, 2, 2, 1'b1, 6, 1, 1, 1, 7, 1, 2, 1, 0, 5); endtask

    // Caller has just made EN/format acceptable at a negedge; SOF must follow two edges later.
    task automatic start_check(input string nm);
        @(posedge clk);
        @(posedge clk); #1;
        chk({nm, " sof at n+1"}, int'(o_sof), 0);
        @(posedge clk); #1;
        chk({nm, " sof at n+2"}, int'(o_sof), 1);
        chk({nm, " hsync with sof"}, int'(o_hsync), 1);
        chk({nm, " field with sof"}, int'(o_field), 0);
    endtask

    task automatic wait_sof(input string nm);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (o_sof && k < 1000);
        do begin @(negedge clk); k++; end while (!o_sof && k < 1000);
        if (!o_sof) chk({nm, " sof timeout"}, int'(o_sof), 1);
    endtask

    // Monitor: each SOF closes the previous window and compares it against the queue head.
    initial begin : monitor
        int   start_cyc;
        int   discard_seen;
        bit   have;
        bit   prev_vs;
        rec_t acc;
        rec_t e;
        have = 1'b0; prev_vs = 1'b0; start_cyc = 0; discard_seen = 0;
        acc = mk("", 0, 0, 0, 0, 0, 0, 0, 0);
        forever begin
            @(negedge clk);
            if (o_sof) begin
                if (have && discard_seen == discard_req) begin
                    acc.period = cyc - start_cyc;
                    if (exp_q.size() == 0) begin
                        chk("unexpected frame, queued", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.period >= 0) chk({e.tag, " period"}, acc.period, e.period);
                        chk({e.tag, " hsync cycles"}, acc.hs, e.hs);
                        chk({e.tag, " vsync cycles"}, acc.vs, e.vs);
                        chk({e.tag, " de cycles"}, acc.de, e.de);
                        chk({e.tag, " x sum"}, acc.xs, e.xs);
                        chk({e.tag, " y sum"}, acc.ys, e.ys);
                        chk({e.tag, " field1 cycles"}, acc.f1, e.f1);
                        chk({e.tag, " xy outside de"}, acc.bad, e.bad);
                        chk({e.tag, " last vsync rise"}, acc.vsr, e.vsr);
                    end
                end
                discard_seen = discard_req;
                have = 1'b1;
                start_cyc = cyc;
                acc = mk("", 0, 0, 0, 0, 0, 0, 0, 0);
            end
            if (have) begin
                acc.hs += int'(o_hsync);
                acc.vs += int'(o_vsync);
                acc.de += int'(o_de);
                acc.f1 += int'(o_field);
                if (o_de) begin
                    acc.xs += int'(o_x);
                    acc.ys += int'(o_y);
                end else if (o_x != '0 || o_y != '0) begin
                    acc.bad++;
                end
                if (o_vsync && !prev_vs) acc.vsr = cyc - start_cyc;
            end
            prev_vs = o_vsync;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int nz;
        i_rst = 1'b1;
        i_en  = 1'b0;
        fmt_a();
        repeat (3) @(negedge clk);
        chk("reset outputs", outs_word(), 0);
        i_rst = 1'b0;

        // Invalid format with EN high: must stay idle.
        set_fmt(0, 1, 2, 2, 1'b0, 8, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        i_en = 1'b1;
        nz = 0;
        repeat (100) begin @(negedge clk); if (outs_word() != 0) nz++; end
        chk("invalid format quiet cycles", nz, 0);

        exp_q.push_back(mk("A1", 80, 16, 10, 25, 50, 50, 0, 0));
        exp_q.push_back(mk("A2", 80, 16, 10, 25, 50, 50, 0, 0));
        exp_q.push_back(mk("A3", 80, 16, 10, 25, 50, 50, 0, 0));
        exp_q.push_back(mk("A4", 80, 16, 10, 25, 50, 50, 0, 0));
        @(negedge clk);
        fmt_a();
        start_check("startup");
        wait_sof("A2 start");
        wait_sof("A3 start");
        wait_sof("A4 start");

        // Mid-frame format switch: A4 must finish at 10-pixel lines.
        repeat (35) @(negedge clk);
        fmt_c();
        exp_q.push_back(mk("C1", 96, 24, 12, 25, 50, 50, 0, 0));
        exp_q.push_back(mk("C2", -1, 24, 12, 25, 50, 50, 0, 0));
        wait_sof("C1 start");
        wait_sof("C2 start");

        // Drop EN mid-frame: C2 completes, then idle with all outputs low.
        repeat (40) @(negedge clk);
        i_en = 1'b0;
        repeat (200) @(negedge clk);
        exp_q.push_back(mk("C3", 96, 24, 12, 25, 50, 50, 0, 0));
        exp_q.push_back(mk("B1", 130, 26, 20, 30, 60, 30, 70, 65));
        exp_q.push_back(mk("B2", 130, 26, 20, 30, 60, 30, 70, 65));
        i_en = 1'b1;
        start_check("restart");

        repeat (30) @(negedge clk);
        fmt_b();
        wait_sof("B1 start");
        wait_sof("B2 start");
        wait_sof("B3 start");

        // Reset mid-line: asynchronous clear, no restart while EN is low.
        repeat (23) @(negedge clk);
        discard_req++;
        i_rst = 1'b1;
        i_en  = 1'b0;
        #1;
        chk("outputs right after rst", outs_word(), 0);
        repeat (3) @(negedge clk);
        chk("outputs during rst", outs_word(), 0);
        i_rst = 1'b0;
        nz = 0;
        repeat (30) begin @(negedge clk); if (outs_word() != 0) nz++; end
        chk("quiet cycles after rst release", nz, 0);
        @(negedge clk);
        i_en = 1'b1;
        start_check("post-reset start");

        repeat (10) @(negedge clk);
        chk("frames left in scoreboard", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
